// File: rtl/mdu_unit.sv
// HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU finish after a fixed busy window,
// MTHI/MTLO write in one cycle, and MFHI/MFLO read combinationally.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SRCA,
  input  logic [31:0] SRCB,
  input  logic [3:0]  MDUop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUresult
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   tmp_hi_q, tmp_lo_q;
  logic          tmp_wr_q;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] mag_a, mag_b, den_s, den_u;
  logic        [31:0] qmag, rmag;
  logic        [31:0] res_hi, res_lo;
  logic               res_wr, res_long;
  logic        [CW-1:0] res_n;

  assign prod_s = $signed({{32{SRCA[31]}}, SRCA}) * $signed({{32{SRCB[31]}}, SRCB});
  assign prod_u = {32'b0, SRCA} * {32'b0, SRCB};

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign mag_a = SRCA[31] ? (32'd0 - SRCA) : SRCA;
  assign mag_b = SRCB[31] ? (32'd0 - SRCB) : SRCB;
  assign den_s = (SRCB == 32'd0) ? 32'd1 : mag_b;
  assign den_u = (SRCB == 32'd0) ? 32'd1 : SRCB;
  assign qmag  = mag_a / den_s;
  assign rmag  = mag_a % den_s;

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    res_wr   = 1'b1;
    res_long = 1'b1;
    res_n    = MULT_N;
    unique case (MDUop)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        res_n  = DIV_N;
        res_wr = (SRCB != 32'd0);
        res_lo = (SRCA[31] ^ SRCB[31]) ? (32'd0 - qmag) : qmag;
        res_hi = SRCA[31] ? (32'd0 - rmag) : rmag;
      end
      OP_DIVU: begin
        res_n  = DIV_N;
        res_wr = (SRCB != 32'd0);
        res_lo = SRCA / den_u;
        res_hi = SRCA % den_u;
      end
      default: begin
        res_wr   = 1'b0;
        res_long = 1'b0;
      end
    endcase
  end

  assign cnt_d = cnt_q - 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      tmp_wr_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (res_long) begin
              tmp_hi_q <= res_hi;
              tmp_lo_q <= res_lo;
              tmp_wr_q <= res_wr;
              cnt_q    <= res_n;
              busy_q   <= 1'b1;
              state_q  <= RUN;
            end else if (MDUop == OP_MTHI) begin
              hi_q <= SRCA;
            end else if (MDUop == OP_MTLO) begin
              lo_q <= SRCA;
            end
          end
        end
        RUN: begin
          // New starts are dropped here; only the countdown advances.
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (tmp_wr_q) begin
              hi_q <= tmp_hi_q;
              lo_q <= tmp_lo_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    MDUresult = 32'd0;
    if (MDUop == OP_MFHI) MDUresult = hi_q;
    else if (MDUop == OP_MFLO) MDUresult = lo_q;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed vector table, hand-written overlap/reset sequences,
// then random ops checked against an arithmetic reference model.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] SRCA, SRCB;
  logic [3:0]  MDUop;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO, MDUresult;

  int checks = 0;
  int errors = 0;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .SRCA(SRCA), .SRCB(SRCB), .MDUop(MDUop),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .MDUresult(MDUresult)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t tbl[14];

  logic [31:0] m_hi, m_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one op for a single cycle, scramble operands afterwards, and time the busy window.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi_e,
                        input logic [31:0] lo_e, input int cyc_e, input bit rd_chk);
    int cnt;
    @(negedge clk);
    SRCA = a; SRCB = b; MDUop = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUop = 4'd0; SRCA = $urandom; SRCB = $urandom;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk_int({name, " busy_cycles"}, cnt, cyc_e);
    chk({name, " HI"}, HI, hi_e);
    chk({name, " LO"}, LO, lo_e);
    if (rd_chk) begin
      MDUop = 4'd5; #1;
      chk({name, " MFHI"}, MDUresult, hi_e);
      MDUop = 4'd6; #1;
      chk({name, " MFLO"}, MDUresult, lo_e);
      MDUop = 4'd0; #1;
      chk({name, " NOP result"}, MDUresult, 32'd0);
    end
  endtask

  // Reference: architectural arithmetic on 64-bit integers.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    longint sa, sb, q, r, p;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    cyc = 0;
    case (op)
      4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; cyc = MC; end
      4'd2: begin pu = ua * ub; m_hi = pu[63:32]; m_lo = pu[31:0]; cyc = MC; end
      4'd3: begin
        cyc = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      4'd4: begin
        cyc = DC;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: ;
    endcase
  endtask

  initial begin
    int cnt;
    logic [3:0] ops[6];
    tbl[0]  = '{4'd1,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, MC};
    tbl[1]  = '{4'd2,  32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC};
    tbl[2]  = '{4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    tbl[3]  = '{4'd7,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 0};
    tbl[4]  = '{4'd4,  32'd5,        32'd0,        32'h12345678, 32'hFFFFFFFD, DC};
    tbl[5]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    tbl[6]  = '{4'd8,  32'h0000BEEF, 32'd0,        32'h00000000, 32'h0000BEEF, 0};
    tbl[7]  = '{4'd4,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, DC};
    tbl[8]  = '{4'd1,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, MC};
    tbl[9]  = '{4'd3,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
    tbl[10] = '{4'd5,  32'd9,        32'd9,        32'h00000001, 32'hFFFFFFFD, 0};
    tbl[11] = '{4'd12, 32'd5,        32'd3,        32'h00000001, 32'hFFFFFFFD, 0};
    tbl[12] = '{4'd3,  32'hFFFFFFF9, 32'd0,        32'h00000001, 32'hFFFFFFFD, DC};
    tbl[13] = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};

    reset = 1'b1; start = 1'b0; MDUop = 4'd0; SRCA = 32'd0; SRCB = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    MDUop = 4'd5; #1;
    chk("reset MFHI", MDUresult, 32'd0);
    MDUop = 4'd0;
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].hi, tbl[i].lo, tbl[i].cyc, 1'b1);

    // Starts issued mid-MULT (MTLO at busy cycle 2, DIV at cycle 3) must be dropped.
    @(negedge clk);
    SRCA = 32'd3; SRCB = 32'd4; MDUop = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUop = 4'd0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      case (cnt)
        2: begin SRCA = 32'h0000DEAD; MDUop = 4'd8; start = 1'b1; end
        3: begin
          chk("overlap LO held", LO, 32'h00000001);
          SRCA = 32'd100; SRCB = 32'd3; MDUop = 4'd3; start = 1'b1;
        end
        default: begin start = 1'b0; MDUop = 4'd0; end
      endcase
      @(negedge clk);
    end
    start = 1'b0; MDUop = 4'd0;
    chk_int("overlap busy_cycles", cnt, MC);
    chk("overlap HI", HI, 32'd0);
    chk("overlap LO", LO, 32'h0000000C);

    // Reset between edges during a DIV discards everything.
    run_op("pre-reset MTHI", 4'd7, 32'hAAAA5555, 32'd0, 32'hAAAA5555, 32'h0000000C, 0, 1'b0);
    @(negedge clk);
    SRCA = 32'd100; SRCB = 32'd3; MDUop = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUop = 4'd0;
    repeat (2) @(negedge clk);
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset HI", HI, 32'd0);
    chk("midreset LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (DC + 2) @(negedge clk);
    chk("postreset busy", {31'd0, busy}, 32'd0);
    chk("postreset HI", HI, 32'd0);
    chk("postreset LO", LO, 32'd0);

    m_hi = 32'd0; m_lo = 32'd0;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      int cyc;
      op = ops[$urandom_range(0, 5)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 9);
        2: b = 32'd0 - $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      model(op, a, b, cyc);
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b, m_hi, m_lo, cyc, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
